// File: rtl/root_5_multi_cycle.sv
`default_nettype none
// ============================================================================
//  Module   : root_5_multi_cycle
//  Purpose  : Integer fifth root, floor(arg^(1/5)), over a valid/ready
//             handshake. A bit-serial search builds the root MSB first.
//             Each trial candidate is raised to the fifth power with one
//             shared multiplier over four cycles, then compared against
//             the argument in a fifth cycle.
//  Revision : 1.0  initial release
// ============================================================================
module root_5_multi_cycle #(
   parameter int W = 16
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   i_arg_vld,
   output logic                   o_arg_rdy,
   input  logic [W-1:0]           i_arg,
   output logic                   o_res_vld,
   output logic [(W+4)/5-1:0]     o_res
);

   // Result width, accumulator width (holds cand^5 without loss), bit-index width
   localparam int c_RW = (W + 4) / 5;
   localparam int c_AW = 5 * c_RW;
   localparam int c_BW = (c_RW > 1) ? $clog2(c_RW) : 1;

   localparam logic [c_RW-1:0] c_TOP_BIT = c_RW'(1) << (c_RW - 1);
   localparam logic [c_BW-1:0] c_TOP_IDX = c_BW'(c_RW - 1);

   localparam logic [1:0] c_S_IDLE = 2'd0;
   localparam logic [1:0] c_S_MUL  = 2'd1;
   localparam logic [1:0] c_S_CMP  = 2'd2;

   logic [1:0]      r_state;
   logic [1:0]      w_state_nxt;
   logic [W-1:0]    r_arg;
   logic [c_RW-1:0] r_root;
   logic [c_BW-1:0] r_b;
   logic [c_AW-1:0] r_acc;
   logic [1:0]      r_mcnt;
   logic [c_RW-1:0] r_res;
   logic            r_res_vld;

   logic [c_RW-1:0] w_cand;
   logic [c_AW-1:0] w_prod;
   logic            w_fits;
   logic [c_RW-1:0] w_root_upd;
   logic [c_BW-1:0] w_b_dec;
   logic [c_RW-1:0] w_next_cand;
   logic            w_accept;

   // Search datapath: trial candidate, its running power, and the compare result
   always_comb begin
      w_cand      = r_root | (c_RW'(1) << r_b);
      w_prod      = r_acc * c_AW'(w_cand);
      w_fits      = (r_acc <= c_AW'(r_arg));
      w_root_upd  = w_fits ? w_cand : r_root;
      w_b_dec     = r_b - c_BW'(1);
      w_next_cand = w_root_upd | (c_RW'(1) << w_b_dec);
      w_accept    = i_arg_vld && (r_state == c_S_IDLE);
   end

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= c_S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state logic: four MUL cycles per bit, then one CMP cycle
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         c_S_IDLE: if (i_arg_vld) w_state_nxt = c_S_MUL;
         c_S_MUL:  if (r_mcnt == 2'd3) w_state_nxt = c_S_CMP;
         c_S_CMP:  w_state_nxt = (r_b == '0) ? c_S_IDLE : c_S_MUL;
         default:  w_state_nxt = c_S_IDLE;
      endcase
   end

   // Output logic: ready only while idle
   always_comb begin
      o_arg_rdy = (r_state == c_S_IDLE);
   end

   // Datapath registers; the accumulator is seeded with the candidate itself,
   // so four multiplies leave cand^5 in it
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_arg     <= '0;
         r_root    <= '0;
         r_b       <= '0;
         r_acc     <= '0;
         r_mcnt    <= '0;
         r_res     <= '0;
         r_res_vld <= 1'b0;
      end else begin
         r_res_vld <= 1'b0;
         case (r_state)
            c_S_IDLE: begin
               if (w_accept) begin
                  r_arg  <= i_arg;
                  r_root <= '0;
                  r_b    <= c_TOP_IDX;
                  r_acc  <= c_AW'(c_TOP_BIT);
                  r_mcnt <= '0;
               end
            end
            c_S_MUL: begin
               r_acc  <= w_prod;
               r_mcnt <= r_mcnt + 2'd1;
            end
            c_S_CMP: begin
               r_root <= w_root_upd;
               if (r_b == '0) begin
                  r_res     <= w_root_upd;
                  r_res_vld <= 1'b1;
               end else begin
                  r_b    <= w_b_dec;
                  r_acc  <= c_AW'(w_next_cand);
                  r_mcnt <= '0;
               end
            end
            default: ;
         endcase
      end
   end

   // Registered result outputs
   always_comb begin
      o_res     = r_res;
      o_res_vld = r_res_vld;
   end

endmodule
`default_nettype wire

// File: tb/tb_root_5_multi_cycle.sv
`default_nettype none
// ============================================================================
//  Module   : tb_root_5_multi_cycle
//  Purpose  : Scoreboard bench for root_5_multi_cycle (W = 16). Accepted
//             arguments push a reference floor fifth root; a monitor pops
//             on every result pulse and checks value and latency.
//  Revision : 1.0  initial release
// ============================================================================
module tb_root_5_multi_cycle;

   logic        clk;
   logic        rst_n;
   logic        i_arg_vld;
   logic        o_arg_rdy;
   logic [15:0] i_arg;
   logic        o_res_vld;
   logic [3:0]  o_res;

   int n_chk  = 0;
   int n_pass = 0;
   int n_sent = 0;
   int n_acc  = 0;
   int n_res  = 0;
   int cyc    = 0;

   int exp_q[$];
   int e0_q[$];
   int acc_hist[$];

   root_5_multi_cycle #(.W(16)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_arg_vld (i_arg_vld),
      .o_arg_rdy (o_arg_rdy),
      .i_arg     (i_arg),
      .o_res_vld (o_res_vld),
      .o_res     (o_res)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Reference: largest r with r^5 <= a, by plain search
   function automatic int root5(input int a);
      int r = 0;
      longint p;
      forever begin
         p = longint'(r + 1) * (r + 1) * (r + 1) * (r + 1) * (r + 1);
         if (p > a) break;
         r++;
      end
      return r;
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      n_chk++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
   endtask

   // Monitor / scoreboard
   always @(negedge clk) begin
      if (rst_n) begin
         if (i_arg_vld && o_arg_rdy) begin
            exp_q.push_back(root5(int'(i_arg)));
            e0_q.push_back(cyc + 1);
            acc_hist.push_back(cyc + 1);
            n_acc++;
         end
         if (o_res_vld) begin
            n_res++;
            if (exp_q.size() == 0) begin
               chk("unexpected_res_vld", 1, 0);
            end else begin
               chk("res_value", int'(o_res), exp_q.pop_front());
               chk("latency", cyc - e0_q.pop_front(), 20);
            end
         end
      end
   end

   // Present an argument (caller is just after a rising edge) and hold it until accepted
   task automatic send(input int a, input bit keep);
      int n = 0;
      i_arg     = 16'(a);
      i_arg_vld = 1'b1;
      n_sent++;
      @(negedge clk);
      while (!o_arg_rdy && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (n >= 100) chk("accept_timeout", n, 0);
      @(posedge clk);
      #1;
      if (!keep) begin
         i_arg_vld = 1'b0;
         i_arg     = 16'($urandom);
      end
   endtask

   task automatic drain();
      int n = 0;
      while ((exp_q.size() != 0 || !o_arg_rdy) && n < 200) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (n >= 200) chk("drain_timeout", n, 0);
   endtask

   int bnd[] = '{0, 1, 31, 32, 242, 243, 59048, 59049, 65535};
   int r0;
   int a0;

   initial begin
      rst_n     = 1'b0;
      i_arg_vld = 1'b0;
      i_arg     = '0;
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;

      // Reset state and quiet idle period
      chk("reset_arg_rdy", int'(o_arg_rdy), 1);
      chk("reset_res_vld", int'(o_res_vld), 0);
      chk("reset_res",     int'(o_res), 0);
      r0 = n_res;
      repeat (50) @(posedge clk);
      #1;
      chk("idle_no_res", n_res - r0, 0);

      // Boundaries, one at a time
      foreach (bnd[i]) begin
         send(bnd[i], 1'b0);
         drain();
      end

      // Back-to-back with arg_vld held high
      a0 = acc_hist.size();
      send(1024, 1'b1);
      send(3125, 1'b0);
      drain();
      if (acc_hist.size() == a0 + 2)
         chk("b2b_accept_gap", acc_hist[a0+1] - acc_hist[a0], 21);
      else
         chk("b2b_accept_count", acc_hist.size() - a0, 2);

      // arg_vld pulses while busy must not create results
      r0 = n_res;
      send(777, 1'b0);
      for (int i = 0; i < 10; i++) begin
         i_arg_vld = 1'($urandom);
         i_arg     = 16'($urandom);
         @(posedge clk);
         #1;
      end
      i_arg_vld = 1'b0;
      repeat (30) @(posedge clk);
      #1;
      chk("busy_pulses_one_result", n_res - r0, 1);

      // Reset in the middle of a computation
      r0 = n_res;
      send(65535, 1'b0);
      repeat (6) @(posedge clk);
      #1;
      rst_n = 1'b0;
      exp_q.delete();
      e0_q.delete();
      n_sent--;
      n_acc--;
      #1;
      chk("midrst_arg_rdy", int'(o_arg_rdy), 1);
      chk("midrst_res_vld", int'(o_res_vld), 0);
      chk("midrst_res",     int'(o_res), 0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (30) @(posedge clk);
      #1;
      chk("midrst_no_res", n_res - r0, 0);
      send(243, 1'b0);
      drain();

      // Loop closure with fifth powers of 0..9
      for (int i = 0; i <= 9; i++) begin
         send(i * i * i * i * i, 1'b0);
         drain();
      end

      // Around every power boundary
      for (int r = 1; r <= 9; r++) begin
         send(r * r * r * r * r - 1, 1'b0);
         send(r * r * r * r * r, 1'b0);
      end
      drain();

      // Random arguments, mixed with idle gaps
      for (int i = 0; i < 1500; i++) begin
         send(int'($urandom_range(65535, 0)), 1'(i % 2));
         if ($urandom_range(3, 0) == 0) begin
            i_arg_vld = 1'b0;
            repeat ($urandom_range(3, 0)) @(posedge clk);
            #1;
         end
      end
      i_arg_vld = 1'b0;
      drain();
      repeat (5) @(posedge clk);
      #1;

      chk("accept_count", n_acc, n_sent);
      chk("result_count", n_res, n_sent);
      chk("scoreboard_empty", exp_q.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
`default_nettype wire
